fold_scheduler: RTL and testbench

FOLD_SCHEDULER -- requirements
Module: fold_scheduler

---
 rtl/fold_scheduler.sv | 98 +++++++++
 tb/tb_fold_scheduler.sv | 115 +++++++++++
 2 files changed

// File: rtl/fold_scheduler.sv
// Sequencer for one folded convolution: clears the accumulator, streams N tap
// reads to the fmaps/weight SRAMs, then latches the result and holds it for the consumer.
module fold_scheduler #(
    parameter int ADDR_W    = 6,
    parameter int WBANK_OFS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              weight_select,
    input  logic [ADDR_W-1:0] fmap_base,
    input  logic [4:0]        tap_count,
    input  logic              out_ready,
    output logic              ce,
    output logic              we,
    output logic [ADDR_W-1:0] addr_fmaps,
    output logic [ADDR_W-1:0] addr_weight,
    output logic              acc_clr,
    output logic              worken,
    output logic              outputen,
    output logic              busy,
    output logic              out_valid,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    // SRAM read latency between ce and valid data at the MAC
    localparam int STAGES = 1;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] base;
        logic [4:0]        last;
    } cfg_t;

    logic [2:0]        state, state_nxt;
    logic [4:0]        k;
    cfg_t              cfg;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic              launch;

    assign launch = (state == S_IDLE) && start && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_RUN;
            S_RUN:   if (k == cfg.last) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_HOLD;
            S_HOLD:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            cfg   <= '0;
            vld_q <= '0;
        end else begin
            state <= state_nxt;
            // an abort must not let an in-flight read reach the MAC
            vld_q <= abort ? '0 : vld_pipe[STAGES-1:0];
            if ((state == S_RUN) && (state_nxt == S_RUN)) k <= k + 5'd1;
            else k <= '0;
            if (launch) begin
                cfg.bank <= weight_select;
                cfg.base <= fmap_base;
                cfg.last <= tap_count;
            end
        end
    end

    assign vld_pipe    = {vld_q, ce};
    assign ce          = (state == S_RUN);
    assign we          = 1'b0;
    assign acc_clr     = (state == S_CLR);
    assign worken      = vld_pipe[STAGES];
    assign outputen    = (state == S_LATCH);
    assign out_valid   = (state == S_HOLD);
    assign busy        = (state != S_IDLE);
    assign done        = out_valid && out_ready && !abort && !rst;
    assign addr_fmaps  = ce ? cfg.base + ADDR_W'(k) : '0;
    assign addr_weight = ce ? ADDR_W'(k) + (cfg.bank ? ADDR_W'(WBANK_OFS) : '0) : '0;

endmodule

// File: tb/tb_fold_scheduler.sv
// Directed bench for fold_scheduler: cycle-by-cycle control timing, addresses,
// backpressure, abort, mid-run reset and tap-count boundaries.
module tb_fold_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, abort, weight_select, out_ready;
    logic [5:0] fmap_base;
    logic [4:0] tap_count;
    logic       ce, we, acc_clr, worken, outputen, busy, out_valid, done;
    logic [5:0] addr_fmaps, addr_weight;

    int n_cmp = 0;
    int n_err = 0;

    fold_scheduler #(.ADDR_W(6), .WBANK_OFS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .weight_select(weight_select), .fmap_base(fmap_base),
        .tap_count(tap_count), .out_ready(out_ready),
        .ce(ce), .we(we), .addr_fmaps(addr_fmaps), .addr_weight(addr_weight),
        .acc_clr(acc_clr), .worken(worken), .outputen(outputen),
        .busy(busy), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // drive one cycle's inputs at negedge, settle, then outputs are sampled by the caller
    task automatic step(input logic s, input logic a, input logic r, input logic rs);
        @(negedge clk);
        start = s; abort = a; out_ready = r; rst = rs;
        #1;
    endtask

    // ctl vector order: busy ce we acc_clr worken outputen out_valid done
    task automatic run(input int id, input int tc, input logic [5:0] base, input logic bank,
                       input int rdy, input int abrt, input int rstc, input logic spam,
                       input int tail);
        int n, endc, kill, nce, nwk, ndn;
        logic e_ce, e_wk, e_busy, e_done;
        logic [7:0] got, exp;
        logic [5:0] ef, ew;
        n = tc + 1;
        endc = n + 4 + rdy;
        kill = (abrt >= 0) ? abrt : ((rstc >= 0) ? rstc : 1 << 30);
        nce = 0; nwk = 0; ndn = 0;
        fmap_base = base; tap_count = tc[4:0]; weight_select = bank;
        for (int c = 0; c <= endc + tail; c++) begin
            step((c == 0) || (spam && c >= 1 && c <= endc), c == abrt,
                 (rdy == 0) ? 1'b1 : (c >= endc), c == rstc);
            e_ce   = (c <= kill) && (c >= 2) && (c <= n + 1);
            e_wk   = (c <= kill) && (c >= 3) && (c <= n + 2);
            e_busy = (c <= kill) && (c >= 1) && (c <= endc);
            e_done = (c <= kill) && (c == endc) && (c != abrt) && (c != rstc);
            exp = {e_busy, e_ce, 1'b0, (c <= kill) && (c == 1), e_wk,
                   (c <= kill) && (c == n + 3),
                   (c <= kill) && (c >= n + 4) && (c <= endc), e_done};
            got = {busy, ce, we, acc_clr, worken, outputen, out_valid, done};
            chk($sformatf("r%0d c%0d ctl", id, c), {24'd0, got}, {24'd0, exp});
            if (e_ce) begin
                ef = base + 6'(c - 2);
                ew = 6'(c - 2) + (bank ? 6'd32 : 6'd0);
                chk($sformatf("r%0d c%0d addr_fmaps", id, c), {26'd0, addr_fmaps}, {26'd0, ef});
                chk($sformatf("r%0d c%0d addr_weight", id, c), {26'd0, addr_weight}, {26'd0, ew});
            end else if (!e_busy) begin
                chk($sformatf("r%0d c%0d idle_addr", id, c), {20'd0, addr_fmaps, addr_weight}, 32'd0);
            end
            nce += int'(ce); nwk += int'(worken); ndn += int'(done);
        end
        if (kill > endc) begin
            chk($sformatf("r%0d ce_count", id), nce, n);
            chk($sformatf("r%0d worken_count", id), nwk, n);
            chk($sformatf("r%0d done_count", id), ndn, 1);
        end else begin
            chk($sformatf("r%0d done_count", id), ndn, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        weight_select = 1'b0; fmap_base = '0; tap_count = '0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("reset ctl", {24'd0, busy, ce, we, acc_clr, worken, outputen, out_valid, done}, 32'd0);
        chk("reset addr", {20'd0, addr_fmaps, addr_weight}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // start and abort together in IDLE: abort wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_abort busy", {31'd0, busy}, 32'd0);
        chk("start_abort acc_clr", {31'd0, acc_clr}, 32'd0);

        run(1, 8, 6'd0, 1'b0, 0, -1, -1, 1'b0, 2);    // basic run
        run(2, 7, 6'd60, 1'b1, 0, -1, -1, 1'b0, 0);   // bank 1, fmaps wrap
        run(3, 2, 6'd5, 1'b0, 0, -1, -1, 1'b0, 1);    // back-to-back start
        run(4, 3, 6'd10, 1'b1, 5, -1, -1, 1'b1, 2);   // backpressure, start spam
        run(5, 8, 6'd0, 1'b0, 0, 4, -1, 1'b0, 2);     // abort on 3rd RUN cycle
        run(6, 1, 6'd0, 1'b0, 0, 6, -1, 1'b0, 2);     // abort beats out_ready in HOLD
        run(7, 4, 6'd3, 1'b0, 0, -1, 7, 1'b0, 1);     // reset during DRAIN
        run(8, 4, 6'd3, 1'b0, 0, -1, -1, 1'b0, 1);    // clean run after reset
        run(9, 0, 6'd63, 1'b1, 0, -1, -1, 1'b0, 1);   // single tap
        run(10, 31, 6'd40, 1'b1, 0, -1, -1, 1'b0, 1); // 32 taps

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
